// File: rtl/battleship_pkg.sv
// ============================================================================
//  battleship_pkg : shared board geometry, cell index type and PC shot states
//  Revision 1.0
// ============================================================================
`default_nettype none

package battleship_pkg;

  localparam int BOARD_DIM  = 5;
  localparam int CELL_COUNT = BOARD_DIM * BOARD_DIM;
  localparam int COORD_W    = 3;

  typedef logic [4:0]         cell_idx_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    THINK  = 3'd1,
    SAMPLE = 3'd2,
    PROBE  = 3'd3,
    ISSUE  = 3'd4
  } pc_shot_state_t;

  // Raw 3-bit random values fold 5..7 back onto 0..2.
  function automatic coord_t reduce_coord(input coord_t raw);
    return (raw >= coord_t'(BOARD_DIM)) ? raw - coord_t'(BOARD_DIM) : raw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cell_idx_split.sv
// ============================================================================
//  cell_idx_split : combinational linear cell index -> (row, col)
//  Revision 1.0
// ============================================================================
`default_nettype none

module cell_idx_split
  import battleship_pkg::*;
(
  input  logic [4:0] idx,
  output logic [2:0] row,
  output logic [2:0] col
);

  localparam cell_idx_t c_dim = cell_idx_t'(BOARD_DIM);

  always_comb begin
    row = coord_t'(idx / c_dim);
    col = coord_t'(idx % c_dim);
  end

endmodule

`default_nettype wire

// File: rtl/pc_shot_generator.sv
// ============================================================================
//  pc_shot_generator : picks a never-before-targeted cell for the PC's turn
//  Revision 1.0
// ============================================================================
`default_nettype none

module pc_shot_generator
  import battleship_pkg::*;
#(
  parameter int THINK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] rand_row,
  input  logic [2:0] rand_col,
  input  logic       shot_ack,
  input  logic       clear_history,
  output logic [2:0] shot_row,
  output logic [2:0] shot_col,
  output logic       shot_valid,
  output logic       busy,
  output logic       board_full
);

  localparam int                CNT_W        = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  c_think_last = CNT_W'(THINK_CYCLES - 1);
  localparam cell_idx_t         c_last_idx   = cell_idx_t'(CELL_COUNT - 1);

  pc_shot_state_t          r_state,      w_state;
  logic [CNT_W-1:0]        r_think_cnt,  w_think_cnt;
  cell_idx_t               r_idx,        w_idx;
  logic [CELL_COUNT-1:0]   r_history,    w_history;
  cell_idx_t               r_shot_count, w_shot_count;
  logic                    r_board_full, w_board_full;
  logic [2:0]              r_row,        w_row;
  logic [2:0]              r_col,        w_col;
  logic                    r_valid,      w_valid;
  logic                    r_busy,       w_busy;

  cell_idx_t               w_sample_idx;
  logic [2:0]              w_split_row;
  logic [2:0]              w_split_col;

  cell_idx_split u_split (
    .idx (r_idx),
    .row (w_split_row),
    .col (w_split_col)
  );

  assign w_sample_idx = cell_idx_t'(reduce_coord(rand_row)) * cell_idx_t'(BOARD_DIM)
                      + cell_idx_t'(reduce_coord(rand_col));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_think_cnt  <= '0;
      r_idx        <= '0;
      r_history    <= '0;
      r_shot_count <= '0;
      r_board_full <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_think_cnt  <= w_think_cnt;
      r_idx        <= w_idx;
      r_history    <= w_history;
      r_shot_count <= w_shot_count;
      r_board_full <= w_board_full;
      r_row        <= w_row;
      r_col        <= w_col;
      r_valid      <= w_valid;
      r_busy       <= w_busy;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_think_cnt  = r_think_cnt;
    w_idx        = r_idx;
    w_history    = r_history;
    w_shot_count = r_shot_count;
    w_board_full = r_board_full;
    w_row        = r_row;
    w_col        = r_col;
    w_valid      = r_valid;

    if (clear_history) begin
      w_state      = IDLE;
      w_history    = '0;
      w_shot_count = '0;
      w_board_full = 1'b0;
      w_valid      = 1'b0;
      w_row        = '0;
      w_col        = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !r_board_full) begin
            w_state     = THINK;
            w_think_cnt = '0;
          end
        end
        THINK: begin
          if (r_think_cnt == c_think_last) begin
            w_state = SAMPLE;
          end else begin
            w_think_cnt = r_think_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          w_idx   = w_sample_idx;
          w_state = PROBE;
        end
        PROBE: begin
          // Linear probe with wrap; a free cell always exists because board_full gates start.
          if (!r_history[r_idx]) begin
            w_row   = w_split_row;
            w_col   = w_split_col;
            w_valid = 1'b1;
            w_state = ISSUE;
          end else begin
            w_idx = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
          end
        end
        ISSUE: begin
          if (shot_ack) begin
            w_history[r_idx] = 1'b1;
            w_shot_count     = r_shot_count + 1'b1;
            w_board_full     = (r_shot_count == c_last_idx);
            w_valid          = 1'b0;
            w_state          = IDLE;
          end
        end
        default: begin
          w_state = IDLE;
        end
      endcase
    end

    w_busy = (w_state != IDLE);
  end

  assign shot_row   = r_row;
  assign shot_col   = r_col;
  assign shot_valid = r_valid;
  assign busy       = r_busy;
  assign board_full = r_board_full;

endmodule

`default_nettype wire

// File: tb/tb_pc_shot_generator.sv
// ============================================================================
//  tb_pc_shot_generator : scoreboard bench for the PC shot generator
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_pc_shot_generator;
  import battleship_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       shot_ack = 1'b0;
  logic       clear_history = 1'b0;
  logic [2:0] rand_row = 3'd0;
  logic [2:0] rand_col = 3'd0;
  logic [2:0] shot_row;
  logic [2:0] shot_col;
  logic       shot_valid;
  logic       busy;
  logic       board_full;

  pc_shot_generator #(.THINK_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .rand_row      (rand_row),
    .rand_col      (rand_col),
    .shot_ack      (shot_ack),
    .clear_history (clear_history),
    .shot_row      (shot_row),
    .shot_col      (shot_col),
    .shot_valid    (shot_valid),
    .busy          (busy),
    .board_full    (board_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    int         lat;
    int         idx;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  bit   model_hist [25];
  int   model_count = 0;
  exp_t sb [$];

  function automatic logic [2:0] red(input logic [2:0] v);
    return (v >= 3'd5) ? v - 3'd5 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 25; i++) model_hist[i] = 1'b0;
    model_count = 0;
  endtask

  task automatic push_expect(input logic [2:0] rr, input logic [2:0] rc);
    exp_t e;
    int   idx;
    int   k;
    idx = int'(red(rr)) * 5 + int'(red(rc));
    k   = 0;
    while (model_hist[idx] && k < 25) begin
      idx = (idx == 24) ? 0 : idx + 1;
      k++;
    end
    e.row = 3'(idx / 5);
    e.col = 3'(idx % 5);
    e.lat = 7 + k;
    e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_history = 1'b1;
    @(posedge clk);
    #1 clear_history = 1'b0;
    model_clear();
  endtask

  // One full request/ack round; noise pulses start and shot_ack while thinking.
  task automatic run_shot(input logic [2:0] rr, input logic [2:0] rc, input bit noise, input string name);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    rand_row = rr;
    rand_col = rc;
    start    = 1'b1;
    push_expect(rr, rc);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      start    = 1'b0;
      shot_ack = 1'b0;
      if (shot_valid) got = 1'b1;
      else if (noise && n == 2) begin
        start    = 1'b1;
        shot_ack = 1'b1;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!got || n != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (valid=%0b), expected %0d", name, n, got, e.lat);
    end
    checks++;
    if ({shot_row, shot_col} !== {e.row, e.col}) begin
      errors++;
      $display("FAIL %s target: got (%0d,%0d), expected (%0d,%0d)", name, shot_row, shot_col, e.row, e.col);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({shot_valid, busy, shot_row, shot_col} !== {1'b1, 1'b1, e.row, e.col}) begin
      errors++;
      $display("FAIL %s hold: got valid=%0b busy=%0b (%0d,%0d), expected 1 1 (%0d,%0d)",
               name, shot_valid, busy, shot_row, shot_col, e.row, e.col);
    end
    @(negedge clk);
    shot_ack = 1'b1;
    @(posedge clk);
    #1 shot_ack = 1'b0;
    model_hist[e.idx] = 1'b1;
    model_count++;
    checks++;
    if ({shot_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s after_ack: got valid=%0b busy=%0b, expected 0 0", name, shot_valid, busy);
    end
    checks++;
    if (dut.r_history[e.idx] !== 1'b1) begin
      errors++;
      $display("FAIL %s history[%0d]: got %0b, expected 1", name, e.idx, dut.r_history[e.idx]);
    end
    checks++;
    if (board_full !== (model_count == 25)) begin
      errors++;
      $display("FAIL %s board_full: got %0b, expected %0b", name, board_full, (model_count == 25));
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({shot_valid, busy, board_full, shot_row, shot_col} !== 9'd0) begin
      errors++;
      $display("FAIL reset outputs: got valid=%0b busy=%0b full=%0b (%0d,%0d), expected all 0",
               shot_valid, busy, board_full, shot_row, shot_col);
    end
    checks++;
    if (dut.r_history !== 25'd0) begin
      errors++;
      $display("FAIL reset history: got %h, expected 0", dut.r_history);
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    run_shot(3'd3, 3'd2, 1'b0, "first_shot");
    run_shot(3'd3, 3'd2, 1'b0, "repeat_probe");
    run_shot(3'd7, 3'd6, 1'b1, "reduce_and_ignore");
  endtask

  task automatic test_wrap();
    run_shot(3'd4, 3'd4, 1'b0, "fill_24");
    run_shot(3'd0, 3'd0, 1'b0, "fill_0");
    run_shot(3'd4, 3'd4, 1'b0, "wrap_probe");
  endtask

  task automatic test_clear_in_probe();
    bit stray;
    do_clear();
    run_shot(3'd0, 3'd0, 1'b0, "pre_clear");
    @(negedge clk);
    rand_row = 3'd0;
    rand_col = 3'd0;
    start    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    @(negedge clk);
    clear_history = 1'b1;
    @(posedge clk);
    #1 clear_history = 1'b0;
    model_clear();
    checks++;
    if ({shot_valid, busy} !== 2'b00 || dut.r_history !== 25'd0) begin
      errors++;
      $display("FAIL clear_probe: got valid=%0b busy=%0b history=%h, expected 0 0 0",
               shot_valid, busy, dut.r_history);
    end
    stray = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (shot_valid || busy) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL clear_probe_quiet: got activity=%0b, expected 0", stray);
    end
  endtask

  task automatic test_reset_in_issue();
    int n;
    run_shot(3'd2, 3'd2, 1'b0, "pre_reset");
    @(negedge clk);
    rand_row = 3'd1;
    rand_col = 3'd1;
    start    = 1'b1;
    n = 0;
    while (!shot_valid && n < 40) begin
      @(posedge clk);
      n++;
      #1 start = 1'b0;
    end
    checks++;
    if (shot_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_issue_reach: got valid=%0b, expected 1", shot_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({shot_valid, busy, board_full, shot_row, shot_col} !== 9'd0 || dut.r_history !== 25'd0) begin
      errors++;
      $display("FAIL reset_issue: got valid=%0b busy=%0b full=%0b (%0d,%0d) history=%h, expected all 0",
               shot_valid, busy, board_full, shot_row, shot_col, dut.r_history);
    end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    run_shot(3'd1, 3'd1, 1'b0, "post_reset");
  endtask

  task automatic test_board_full();
    bit active;
    do_clear();
    for (int i = 0; i < 25; i++) begin
      run_shot(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, "fill_round");
    end
    checks++;
    if (dut.r_history !== {25{1'b1}}) begin
      errors++;
      $display("FAIL full_history: got %h, expected %h", dut.r_history, {25{1'b1}});
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    active = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (shot_valid || busy) active = 1'b1;
    end
    checks++;
    if (active !== 1'b0 || board_full !== 1'b1) begin
      errors++;
      $display("FAIL start_when_full: got activity=%0b full=%0b, expected 0 1", active, board_full);
    end
    do_clear();
    checks++;
    if (board_full !== 1'b0) begin
      errors++;
      $display("FAIL clear_full: got %0b, expected 0", board_full);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_wrap();
    test_clear_in_probe();
    test_reset_in_issue();
    test_board_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
